// File: rtl/exec_ctrl.sv
// Execution controller: gates datapath commits with run/halt/step-N, one PC breakpoint and illegal-insn halt.
// Optional perf counters (cycle/retire) are built only when EXEC_CTRL_PERF_EN is defined.
module exec_ctrl #(
    parameter bit RUN_ON_RST = 1'b1,
    parameter int STEP_W     = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cmd_vld,
    input  logic [1:0]        i_cmd,
    input  logic [STEP_W-1:0] i_step_n,
    input  logic [31:0]       i_pc,
    input  logic              i_insn_vld,
    input  logic              i_bp_en,
    input  logic [31:0]       i_bp_addr,
    output logic              o_pc_en,
    output logic              o_halted,
    output logic [2:0]        o_halt_cause,
    output logic [31:0]       o_halt_pc,
    output logic [31:0]       o_cycle_cnt,
    output logic [31:0]       o_retire_cnt
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_STEP = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    localparam logic [1:0] CMD_HALT = 2'b00;
    localparam logic [1:0] CMD_RUN  = 2'b01;
    localparam logic [1:0] CMD_STEP = 2'b10;

    localparam logic [2:0] CAUSE_NONE    = 3'd0;
    localparam logic [2:0] CAUSE_CMD     = 3'd1;
    localparam logic [2:0] CAUSE_STEP    = 3'd2;
    localparam logic [2:0] CAUSE_BP      = 3'd3;
    localparam logic [2:0] CAUSE_ILLEGAL = 3'd4;

    state_e            state_q, state_d;
    logic [STEP_W-1:0] step_left_q, step_left_d;
    logic              bp_skip_q, bp_skip_d;
    logic [2:0]        cause_q, cause_d;
    logic [31:0]       halt_pc_q, halt_pc_d;
    logic              pc_pend_q, pc_pend_d;

    logic active;
    logic bp_hit;
    logic retire;
    logic cmd_halt;
    logic cmd_run;
    logic cmd_step;

    assign active   = (state_q == ST_RUN) || (state_q == ST_STEP);
    assign bp_hit   = i_bp_en && (i_pc == i_bp_addr) && !bp_skip_q;
    assign retire   = active && i_insn_vld && !bp_hit;
    assign cmd_halt = i_cmd_vld && (i_cmd == CMD_HALT);
    assign cmd_run  = i_cmd_vld && (i_cmd == CMD_RUN);
    assign cmd_step = i_cmd_vld && (i_cmd == CMD_STEP);

    assign o_pc_en      = retire;
    assign o_halted     = (state_q == ST_HALT);
    assign o_halt_cause = cause_q;
    assign o_halt_pc    = halt_pc_q;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path can infer a latch.
        state_d     = state_q;
        step_left_d = step_left_q;
        bp_skip_d   = bp_skip_q;
        cause_d     = cause_q;
        halt_pc_d   = halt_pc_q;
        pc_pend_d   = 1'b0;

        // STEP/CMD halts retire on the entry edge, so the next PC is only visible a cycle later.
        if (pc_pend_q) begin
            halt_pc_d = i_pc;
        end
        if (retire) begin
            bp_skip_d = 1'b0;
        end

        case (state_q)
            ST_RUN, ST_STEP: begin
                if (bp_hit) begin
                    state_d   = ST_HALT;
                    cause_d   = CAUSE_BP;
                    halt_pc_d = i_pc;
                end else if (!i_insn_vld) begin
                    state_d   = ST_HALT;
                    cause_d   = CAUSE_ILLEGAL;
                    halt_pc_d = i_pc;
                end else if ((state_q == ST_STEP) && (step_left_q <= STEP_W'(1))) begin
                    state_d   = ST_HALT;
                    cause_d   = CAUSE_STEP;
                    pc_pend_d = 1'b1;
                end else if (cmd_halt) begin
                    state_d   = ST_HALT;
                    cause_d   = CAUSE_CMD;
                    pc_pend_d = 1'b1;
                end else if (state_q == ST_STEP) begin
                    step_left_d = step_left_q - STEP_W'(1);
                end
            end
            ST_HALT: begin
                if (cmd_run) begin
                    state_d   = ST_RUN;
                    bp_skip_d = 1'b1;
                end else if (cmd_step) begin
                    state_d     = ST_STEP;
                    bp_skip_d   = 1'b1;
                    step_left_d = (i_step_n == '0) ? STEP_W'(1) : i_step_n;
                end
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
        if (i_rst) begin
            state_q     <= RUN_ON_RST ? ST_RUN : ST_HALT;
            step_left_q <= '0;
            bp_skip_q   <= 1'b1;
            cause_q     <= CAUSE_NONE;
            halt_pc_q   <= 32'd0;
            pc_pend_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_left_q <= step_left_d;
            bp_skip_q   <= bp_skip_d;
            cause_q     <= cause_d;
            halt_pc_q   <= halt_pc_d;
            pc_pend_q   <= pc_pend_d;
        end
    end

`ifdef EXEC_CTRL_PERF_EN
    localparam logic [1:0] CMD_CLEAR = 2'b11;

    logic        cmd_clear;
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] retire_cnt_q, retire_cnt_d;

    assign cmd_clear = i_cmd_vld && (i_cmd == CMD_CLEAR);

    always_comb begin
        cycle_cnt_d  = cycle_cnt_q + {31'd0, active};
        retire_cnt_d = retire_cnt_q + {31'd0, retire};
        if (cmd_clear) begin
            cycle_cnt_d  = 32'd0;
            retire_cnt_d = 32'd0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cycle_cnt_q  <= 32'd0;
            retire_cnt_q <= 32'd0;
        end else begin
            cycle_cnt_q  <= cycle_cnt_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign o_cycle_cnt  = cycle_cnt_q;
    assign o_retire_cnt = retire_cnt_q;
`else
    assign o_cycle_cnt  = 32'd0;
    assign o_retire_cnt = 32'd0;
`endif

endmodule

// File: doc/exec_ctrl.md
# exec_ctrl

Execution controller for the single-cycle RV32I core: sequences the datapath by gating its architectural state updates (PC, regfile write, LSU store) through a single enable. Provides run/halt/step-N commands, one PC breakpoint, halt on invalid instruction, and halt-cause/halt-PC capture for a debug host or on-board switch/button logic. Sits between the top-level core wrapper and the program counter, regfile write-enable and LSU write-enable.

## Interface
- RUN_ON_RST, default 1: state entered on reset (1 = RUN, 0 = HALT).
- STEP_W, default 8: width of step-count field.

- i_clk  in  1  core clock
- i_rst  in  1  reset; synchronous, active-high
- i_cmd_vld  in  1  command strobe, one command per cycle
- i_cmd  in  2  00 HALT, 01 RUN, 10 STEP, 11 CLEAR (perf counters)
- i_step_n  in  STEP_W  instruction count for STEP; 0 treated as 1
- i_pc  in  32  current core PC
- i_insn_vld  in  1  controller's valid-instruction flag for i_pc
- i_bp_en  in  1  breakpoint enable
- i_bp_addr  in  32  breakpoint PC, full 32-bit compare
- o_pc_en  out  1  datapath commit enable (gates PC load, rd_wren, mem_wren)
- o_halted  out  1  state == HALT
- o_halt_cause  out  3  0 NONE, 1 CMD, 2 STEP, 3 BP, 4 ILLEGAL
- o_halt_pc  out  32  i_pc captured on halt entry
- o_cycle_cnt  out  32  cycles spent not halted
- o_retire_cnt  out  32  retired instructions

## Operation
- States: RUN, STEP, HALT. Internal: step_left (STEP_W), bp_skip (1).
- bp_hit = i_bp_en & (i_pc == i_bp_addr) & ~bp_skip.
- o_pc_en = (state RUN or STEP) & i_insn_vld & ~bp_hit.
- retire = o_pc_en. Instruction at a breakpoint or invalid instruction is NOT executed.
- RUN: bp_hit -> HALT, cause BP. ~i_insn_vld (no bp_hit) -> HALT, cause ILLEGAL. Else HALT cmd -> HALT, cause CMD. Else stay.
- STEP: same hazard checks as RUN; additionally retire with step_left == 1 -> HALT, cause STEP; retire with step_left > 1 -> step_left - 1.
- HALT: RUN cmd -> RUN; STEP cmd -> STEP, step_left = max(i_step_n, 1). HALT cmd ignored. Cause and halt_pc hold until next halt entry.
- RUN/STEP cmds in RUN or STEP are ignored (no restart of step count).
- Priority of halt causes in one cycle: BP > ILLEGAL > STEP > CMD.
- On every HALT entry o_halt_pc <= i_pc (PC of the un-executed instruction for BP/ILLEGAL; PC of next instruction for STEP/CMD when retire occurred that cycle — i.e. value of i_pc, the core's PC is updated on the same edge, so capture i_pc when no retire, else the commit target is unknown; required: capture i_pc for BP/ILLEGAL, and for STEP/CMD capture i_pc registered one cycle later via a one-cycle pending flag).
- bp_skip: set on HALT->RUN/STEP transition; cleared on first retire. Allows resuming from a breakpoint PC.
- CLEAR accepted in any state; no state change.

## Timing
- o_pc_en combinational from state, i_pc, i_insn_vld, i_bp_*; all other outputs registered.
- Commands sampled at rising edge; effect visible next cycle. HALT cmd: instruction in the command cycle still commits if o_pc_en high.
- o_halt_pc for STEP/CMD valid one cycle after o_halted rises; for BP/ILLEGAL valid with o_halted.
- Reset: state = RUN_ON_RST ? RUN : HALT; o_halt_cause 0; o_halt_pc 0; counters 0; step_left 0; bp_skip 1 (a breakpoint at the reset PC does not fire). Reset mid-step discards step_left.
- Counters wrap at 2^32 silently. CLEAR zeroes both at next edge and overrides that cycle's increment.

## Configuration
- EXEC_CTRL_PERF_EN defined: o_cycle_cnt and o_retire_cnt implemented as above.
- Undefined: both outputs tied to 0, no counter flops; CLEAR cmd accepted and has no effect.

## Test plan
- Reset with RUN_ON_RST=1, valid program at 0x0 -> o_pc_en=1 first cycle; after 10 cycles o_retire_cnt=10, o_cycle_cnt=10.
- i_bp_en=1, i_bp_addr=0x10 -> o_pc_en=0 at PC 0x10, o_halted=1, cause 3, o_halt_pc=0x10; then RUN -> instruction at 0x10 commits, no re-hit.
- From HALT, STEP with i_step_n=3 -> exactly 3 cycles with o_pc_en=1, then cause 2; i_step_n=0 -> exactly 1.
- i_insn_vld=0 at PC 0x24 while RUN -> o_pc_en=0, cause 4, o_halt_pc=0x24; same cycle bp at 0x24 -> cause 3.
- HALT cmd while RUN -> command-cycle instruction commits, halted next cycle, cause 1; CLEAR while counters at 0xFFFFFFFF -> both 0 next cycle.
- i_rst asserted mid STEP(5) after 2 retires -> state per RUN_ON_RST, counters 0, no STEP halt later.
